// File: rtl/dsm_ctrl.sv
// rtl/dsm_ctrl.sv - Sample sequencer for DSM_top: frame hold, soft-start ramp, LFSR dither, overload restart
module dsm_ctrl #(
  parameter int          OSR        = 64,
  parameter int          DITH_EN    = 1,
  parameter int          DITH_SHIFT = 8,
  parameter logic [19:0] RAMP_STEP  = 20'h00040,
  parameter int          OVL_LIMIT  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [19:0] s_data,
  input  logic [1:0]  pwm,
  output logic [19:0] vin,
  output logic [19:0] dith_o,
  output logic        dsm_reset,
  output logic        sample_tick,
  output logic        ovl_flag,
  input  logic        ovl_clr,
  output logic [1:0]  state_o
);
  localparam int                 FW        = $clog2(OSR);
  localparam int                 CW        = $clog2(OVL_LIMIT + 1);
  localparam logic [FW-1:0]      FCNT_LAST = FW'(OSR - 1);
  localparam logic [CW-1:0]      OVL_MAX   = CW'(OVL_LIMIT);
  localparam logic signed [19:0] STEP      = RAMP_STEP;
  localparam logic [15:0]        LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, RAMP = 2'd2, RUN = 2'd3} state_t;
  state_t state, state_nxt;

  logic [1:0]         fl_cnt;
  logic [FW-1:0]      fcnt;
  logic [19:0]        sbuf;
  logic               sbuf_full;
  logic [19:0]        tgt;
  logic [19:0]        vin_r;
  logic [15:0]        lfsr;
  logic [CW-1:0]      ovl_cnt;
  logic [1:0]         pwm_prev;

  logic               active, wrap, ovl_hit, restart, xfer, same_code, close;
  logic [19:0]        tgt_nxt, vin_ramp;
  logic signed [19:0] diff;
  logic signed [19:0] dith_full;

  always_comb begin
    active    = (state == RAMP) || (state == RUN);
    wrap      = active && (fcnt == FCNT_LAST);
    ovl_hit   = active && ((pwm == 2'b10) || (ovl_cnt == OVL_MAX));
    // Dropping enable outranks an overload in the same cycle.
    restart   = ovl_hit && enable;
    s_ready   = active && !sbuf_full;
    xfer      = s_valid && s_ready;
    same_code = (pwm == pwm_prev) && (pwm != 2'b00);
    tgt_nxt   = (wrap && sbuf_full) ? sbuf : tgt;
    diff      = $signed(tgt_nxt) - $signed(vin_r);
    close     = (diff <= STEP) && (diff >= -STEP);
    vin_ramp  = close ? tgt_nxt : (diff[19] ? vin_r - RAMP_STEP : vin_r + RAMP_STEP);

    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = FLUSH;
        FLUSH:   if (fl_cnt == 2'd3) state_nxt = RAMP;
        RAMP:    if (ovl_hit) state_nxt = FLUSH;
                 else if (wrap && close) state_nxt = RUN;
        RUN:     if (ovl_hit) state_nxt = FLUSH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign dith_full   = $signed({{4{lfsr[15]}}, lfsr}) >>> DITH_SHIFT;
  assign dith_o      = ((DITH_EN != 0) && active) ? dith_full : 20'd0;
  assign vin         = vin_r;
  assign dsm_reset   = !active;
  assign sample_tick = active && (fcnt == '0);
  assign state_o     = state;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fl_cnt    <= 2'd0;
      fcnt      <= '0;
      sbuf      <= 20'd0;
      sbuf_full <= 1'b0;
      tgt       <= 20'd0;
      vin_r     <= 20'd0;
      lfsr      <= LFSR_SEED;
      ovl_cnt   <= '0;
      pwm_prev  <= 2'b00;
      ovl_flag  <= 1'b0;
    end else begin
      pwm_prev <= pwm;
      fl_cnt   <= (state == FLUSH) ? fl_cnt + 2'd1 : 2'd0;

      if (active && (state_nxt == state))
        ovl_cnt <= same_code ? ovl_cnt + CW'(1) : '0;
      else
        ovl_cnt <= '0;

      if (active)
        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

      if (active && ((state_nxt == RAMP) || (state_nxt == RUN)))
        fcnt <= wrap ? '0 : fcnt + FW'(1);
      else
        fcnt <= '0;

      // A transfer only happens into an empty buffer, so it never races the wrap-edge unload.
      if (restart) begin
        tgt       <= 20'd0;
        sbuf_full <= 1'b0;
      end else if (active) begin
        if (wrap && sbuf_full) begin
          tgt       <= sbuf;
          sbuf_full <= 1'b0;
        end
        if (xfer) begin
          sbuf      <= s_data;
          sbuf_full <= 1'b1;
        end
      end

      if ((state_nxt == IDLE) || (state_nxt == FLUSH))
        vin_r <= 20'd0;
      else if (wrap)
        vin_r <= (state == RAMP) ? vin_ramp : tgt_nxt;

      if (restart)      ovl_flag <= 1'b1;
      else if (ovl_clr) ovl_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dsm_ctrl.sv
// tb/tb_dsm_ctrl.sv - Directed and randomized checks of dsm_ctrl against a behavioural model
module tb_dsm_ctrl;
  localparam int OSR       = 4;
  localparam int DSHIFT    = 8;
  localparam int STEP      = 'h40;
  localparam int OVL_LIMIT = 32;

  logic        clock = 1'b0;
  logic        reset, enable, s_valid, ovl_clr;
  logic [19:0] s_data;
  logic [1:0]  pwm;
  logic        s_ready, dsm_reset, sample_tick, ovl_flag;
  logic [19:0] vin, dith_o;
  logic [1:0]  state_o;
  logic        s_ready_b, dsm_reset_b, sample_tick_b, ovl_flag_b;
  logic [19:0] vin_b, dith_b;
  logic [1:0]  state_b;

  always #5 clock = ~clock;

  dsm_ctrl #(.OSR(OSR), .DITH_EN(1), .DITH_SHIFT(DSHIFT), .RAMP_STEP(20'h00040), .OVL_LIMIT(OVL_LIMIT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .pwm(pwm), .vin(vin), .dith_o(dith_o), .dsm_reset(dsm_reset),
    .sample_tick(sample_tick), .ovl_flag(ovl_flag), .ovl_clr(ovl_clr), .state_o(state_o));

  dsm_ctrl #(.OSR(OSR), .DITH_EN(0), .DITH_SHIFT(DSHIFT), .RAMP_STEP(20'h00040), .OVL_LIMIT(OVL_LIMIT)) dut_nd (
    .clock(clock), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_data(s_data), .pwm(pwm), .vin(vin_b), .dith_o(dith_b), .dsm_reset(dsm_reset_b),
    .sample_tick(sample_tick_b), .ovl_flag(ovl_flag_b), .ovl_clr(ovl_clr), .state_o(state_b));

  // Model: mode 0 idle, 1 flush, 2 ramp, 3 run; pending samples kept in a queue.
  int          m_state, m_flush_left, m_pos, m_rep;
  logic [19:0] m_q[$];
  logic [19:0] m_tgt, m_vin;
  logic [15:0] m_lfsr;
  logic [1:0]  m_prev;
  logic        m_flag;
  bit          m_known = 1'b0;
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  logic [19:0] vin_hist[$];
  logic [19:0] ramp_seen[$];
  logic [19:0] ramp_exp[4] = '{20'h00040, 20'h00080, 20'h000C0, 20'h00100};

  function automatic int sx20(input logic [19:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [15:0] next_lfsr(input logic [15:0] r);
    logic b;
    b = r[16-16] ^ r[16-14] ^ r[16-13] ^ r[16-11];
    return {b, r[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    bit          act;
    logic [19:0] ed;
    if (!m_known) return;
    act = (m_state >= 2);
    ed  = act ? 20'(sx16(m_lfsr) >>> DSHIFT) : 20'd0;
    chk("state_o", 20'(state_o), 20'(m_state));
    chk("vin", vin, m_vin);
    chk("dith_o", dith_o, ed);
    chk("dith_off", dith_b, 20'd0);
    chk("dsm_reset", 20'(dsm_reset), act ? 20'd0 : 20'd1);
    chk("s_ready", 20'(s_ready), (act && m_q.size() == 0) ? 20'd1 : 20'd0);
    chk("sample_tick", 20'(sample_tick), (act && m_pos == 0) ? 20'd1 : 20'd0);
    chk("ovl_flag", 20'(ovl_flag), 20'(m_flag));
  endtask

  task automatic model_step();
    bit act, wrap, hit, restart, xfer;
    int nxt, d;
    if (reset) begin
      m_known = 1'b1; m_state = 0; m_flush_left = 0; m_pos = 0; m_rep = 0;
      m_q.delete(); m_tgt = 20'd0; m_vin = 20'd0; m_lfsr = 16'hACE1; m_prev = 2'b00; m_flag = 1'b0;
      return;
    end
    if (!m_known) return;
    act     = (m_state >= 2);
    wrap    = act && (m_pos == OSR - 1);
    hit     = act && (pwm == 2'b10 || m_rep >= OVL_LIMIT);
    restart = hit && enable;
    xfer    = act && s_valid && (m_q.size() == 0);

    if (!enable)           nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1) nxt = (m_flush_left == 1) ? 2 : 1;
    else if (hit)          nxt = 1;
    else                   nxt = m_state;

    if (restart) begin
      m_q.delete();
      m_tgt = 20'd0;
    end else if (act) begin
      if (wrap && m_q.size() > 0) m_tgt = m_q.pop_front();
      if (xfer) m_q.push_back(s_data);
    end

    if (nxt < 2) m_vin = 20'd0;
    else if (wrap && m_state == 3) m_vin = m_tgt;
    else if (wrap && m_state == 2) begin
      d = sx20(m_tgt) - sx20(m_vin);
      if (d <= STEP && d >= -STEP) begin
        m_vin = m_tgt;
        nxt   = 3;
      end else begin
        m_vin = 20'(sx20(m_vin) + ((d > 0) ? STEP : -STEP));
      end
    end

    if (nxt != m_state || !act)             m_rep = 0;
    else if (pwm == m_prev && pwm != 2'b00) m_rep++;
    else                                    m_rep = 0;
    m_prev = pwm;

    if (act) m_lfsr = next_lfsr(m_lfsr);
    m_pos = (act && nxt >= 2) ? (m_pos + 1) % OSR : 0;
    if (m_state == 1 && nxt == 1)      m_flush_left--;
    else if (m_state != 1 && nxt == 1) m_flush_left = 4;
    if (restart)      m_flag = 1'b1;
    else if (ovl_clr) m_flag = 1'b0;
    m_state = nxt;
  endtask

  task automatic cycle();
    compare();
    vin_hist.push_back(vin);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [19:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!(m_state >= 2 && m_q.size() == 0) && n < 40) begin
      cycle();
      n++;
    end
    chk("send_wait", (n < 40) ? 20'd1 : 20'd0, 20'd1);
    cycle();
    s_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit);
    int n;
    n = 0;
    while (state_o !== s && n < limit) begin
      cycle();
      n++;
    end
    chk("wait_state", 20'(state_o), 20'(s));
  endtask

  initial begin
    int          n, cnt;
    logic [19:0] last;
    int          r;

    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 20'd0; pwm = 2'b00; ovl_clr = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_state", 20'(state_o), 20'd0);
    chk("rst_dsm_reset", 20'(dsm_reset), 20'd1);
    chk("rst_vin", vin, 20'd0);
    chk("rst_flag", 20'(ovl_flag), 20'd0);
    cycle();

    enable = 1'b1;
    cycle();
    n = 0;
    while (state_o === 2'd1 && n < 10) begin
      n++;
      cycle();
    end
    chk("flush_len", 20'(n), 20'd4);
    chk("ramp_entry_state", 20'(state_o), 20'd2);
    chk("ramp_entry_dsm_reset", 20'(dsm_reset), 20'd0);
    chk("ramp_entry_tick", 20'(sample_tick), 20'd1);
    chk("ramp_entry_vin", vin, 20'd0);
    chk("seed_dither", dith_o, 20'hFFFAC);

    send(20'h00100);
    last = vin;
    n = 0;
    while (state_o !== 2'd3 && n < 40) begin
      cycle();
      n++;
      if (vin !== last) begin
        ramp_seen.push_back(vin);
        last = vin;
      end
    end
    chk("ramp_steps", 20'(ramp_seen.size()), 20'd4);
    for (int i = 0; i < ramp_seen.size() && i < 4; i++) chk("ramp_value", ramp_seen[i], ramp_exp[i]);
    chk("run_vin", vin, 20'h00100);

    vin_hist.delete();
    send(20'h02000);
    chk("s_ready_drop", 20'(s_ready), 20'd0);
    send(20'hFE000);
    for (int i = 0; i < 20; i++) cycle();
    cnt = 0;
    foreach (vin_hist[i]) if (vin_hist[i] === 20'h02000) cnt++;
    chk("hold_02000", 20'(cnt), 20'(OSR));
    chk("repeat_FE000", vin, 20'hFE000);

    pwm = 2'b01;
    n = 0;
    while (ovl_flag !== 1'b1 && n < 60) begin
      cycle();
      n++;
    end
    chk("ovl_flag_set", 20'(ovl_flag), 20'd1);
    chk("ovl_state", 20'(state_o), 20'd1);
    chk("ovl_vin", vin, 20'd0);
    pwm = 2'b00;
    ovl_clr = 1'b1;
    cycle();
    ovl_clr = 1'b0;
    chk("ovl_clr", 20'(ovl_flag), 20'd0);
    wait_state(2'd2, 10);
    chk("restart_vin", vin, 20'd0);

    pwm = 2'b10;
    enable = 1'b0;
    cycle();
    pwm = 2'b00;
    enable = 1'b1;
    chk("illegal_disable_state", 20'(state_o), 20'd0);
    chk("illegal_disable_flag", 20'(ovl_flag), 20'd0);
    wait_state(2'd2, 10);
    pwm = 2'b10;
    cycle();
    pwm = 2'b00;
    chk("illegal_state", 20'(state_o), 20'd1);
    chk("illegal_flag", 20'(ovl_flag), 20'd1);
    ovl_clr = 1'b1;
    cycle();
    ovl_clr = 1'b0;

    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 399) == 0);
      enable  = ($urandom_range(0, 99) != 0);
      s_valid = ($urandom_range(0, 3) == 0);
      s_data  = 20'(int'($urandom_range(0, 32'h8000)) - 32'h4000);
      ovl_clr = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 199));
      if (r == 0)        pwm = 2'b10;
      else if (r < 120)  pwm = (pwm == 2'b10) ? 2'b00 : pwm;
      else begin
        r = int'($urandom_range(0, 2));
        pwm = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      end
      cycle();
    end
    reset = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
